// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_scan_if: digit-load and display-pin bundle between a BCD source and the scan driver
interface bcd_seg_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] an;
  logic frame_done;
  modport master (output load, bcd_in, dp_in, input seg, dp, an, frame_done);
  modport slave (input load, bcd_in, dp_in, output seg, dp, an, frame_done);
endinterface

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: frame-synchronous multiplexed 7-segment driver for packed BCD digits
module bcd_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 100000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_seg_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow, r_disp;
  logic [NUM_DIGITS-1:0] r_shadow_dp, r_disp_dp, w_lz, w_an;
  logic r_pending, r_fe, w_tick, w_fend, w_zero, w_blank;
  logic [3:0] w_dig;
  logic [6:0] w_seg;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction
  assign w_tick = r_pre == PW'(SCAN_DIV - 1);
  assign w_fend = w_tick && r_idx == IW'(NUM_DIGITS - 1);
  always_comb begin
    w_lz = '0;
    w_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero = w_zero && r_disp[4*k +: 4] == 4'd0;
      w_lz[k] = w_zero;
    end
  end
  assign w_dig = r_disp[4*r_idx +: 4];
  assign w_blank = BLANK_LZ && r_idx != '0 && w_lz[r_idx];
  assign w_seg = w_blank ? 7'h00 : seg7(w_dig);
  assign w_an = NUM_DIGITS'(1) << r_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_shadow <= '0;
      r_shadow_dp <= '0;
      r_disp <= '0;
      r_disp_dp <= '0;
      r_pending <= 1'b0;
      r_fe <= 1'b0;
      bus.seg <= {7{ACTIVE_LOW}};
      bus.dp <= ACTIVE_LOW;
      bus.an <= {NUM_DIGITS{ACTIVE_LOW}};
      bus.frame_done <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_idx <= w_fend ? '0 : r_idx + IW'(w_tick);
      r_shadow <= bus.load ? bus.bcd_in : r_shadow;
      r_shadow_dp <= bus.load ? bus.dp_in : r_shadow_dp;
      r_pending <= !w_fend && (r_pending || bus.load);
      r_disp <= !w_fend ? r_disp : bus.load ? bus.bcd_in : r_pending ? r_shadow : r_disp;
      r_disp_dp <= !w_fend ? r_disp_dp : bus.load ? bus.dp_in : r_pending ? r_shadow_dp : r_disp_dp;
      r_fe <= w_fend;
      bus.frame_done <= r_fe;
      bus.seg <= w_seg ^ {7{ACTIVE_LOW}};
      bus.dp <= r_disp_dp[r_idx] ^ ACTIVE_LOW;
      bus.an <= w_an ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end
endmodule
